// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and small helpers for the VGA timing generator.
package vga_pkg;

    // Horizontal timing in pixels
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = 800;

    // Vertical timing in lines
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = 525;

    // Counter widths
    localparam int COUNT_W = 10;
    localparam int FRAME_W = 16;

    // First count value inside the sync pulse
    function automatic int sync_first(input int visible, input int fp);
        return visible + fp;
    endfunction

    // First count value after the sync pulse (exclusive end)
    function automatic int sync_after(input int visible, input int fp, input int sync_w);
        return visible + fp + sync_w;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with decoded sync and visible flags.
// The sync window is [SYNC_START, SYNC_END): SYNC_END is the first count after the pulse.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL,
    parameter int SYNC_START = H_VISIBLE + H_FP,
    parameter int SYNC_END   = H_VISIBLE + H_FP + H_SYNC,
    parameter int VISIBLE    = H_VISIBLE
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               en,
    output logic [COUNT_W-1:0] count,
    output logic               wrap,
    output logic               sync_n,
    output logic               visible
);

    localparam logic [COUNT_W-1:0] LAST    = COUNT_W'(TOTAL - 1);
    localparam logic [COUNT_W-1:0] SYNC_LO = COUNT_W'(SYNC_START);
    localparam logic [COUNT_W-1:0] SYNC_HI = COUNT_W'(SYNC_END);
    localparam logic [COUNT_W-1:0] VIS_END = COUNT_W'(VISIBLE);

    // Advance on enabled edges, wrapping from LAST back to zero
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // wrap marks the edge on which the counter returns to zero
    assign wrap    = en && (count == LAST);
    assign sync_n  = !((count >= SYNC_LO) && (count < SYNC_HI));
    assign visible = (count < VIS_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: Clk/2 pixel clock, x/y counters, syncs, blank, line/frame pulses.
// Geometry defaults to 640x480@60 from vga_pkg; overrides exist so a smaller raster can be used.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE_P = H_VISIBLE,
    parameter int H_FP_P      = H_FP,
    parameter int H_SYNC_P    = H_SYNC,
    parameter int H_TOTAL_P   = H_TOTAL,
    parameter int V_VISIBLE_P = V_VISIBLE,
    parameter int V_FP_P      = V_FP,
    parameter int V_SYNC_P    = V_SYNC,
    parameter int V_TOTAL_P   = V_TOTAL
) (
    input  logic               Clk,
    input  logic               Reset,
    output logic               pixel_clk,
    output logic               hs,
    output logic               vs,
    output logic               blank,
    output logic               sync,
    output logic [COUNT_W-1:0] DrawX,
    output logic [COUNT_W-1:0] DrawY,
    output logic               frame_start,
    output logic               line_start,
    output logic [FRAME_W-1:0] frame_count
);

    logic               ph;
    logic               h_wrap, v_wrap;
    logic               h_sync_n, v_sync_n;
    logic               h_visible, v_visible;
    logic [FRAME_W-1:0] frame_count_q;
    logic               frame_start_q, line_start_q;

    // Counters move only on the ph=1 edge (pixel_clk falling), so DrawX/DrawY
    // are settled by the next pixel_clk rising edge.
    vga_axis_counter #(
        .TOTAL      (H_TOTAL_P),
        .SYNC_START (sync_first(H_VISIBLE_P, H_FP_P)),
        .SYNC_END   (sync_after(H_VISIBLE_P, H_FP_P, H_SYNC_P)),
        .VISIBLE    (H_VISIBLE_P)
    ) u_h (
        .Clk     (Clk),
        .Reset   (Reset),
        .en      (ph),
        .count   (DrawX),
        .wrap    (h_wrap),
        .sync_n  (h_sync_n),
        .visible (h_visible)
    );

    // Vertical axis steps once per horizontal wrap
    vga_axis_counter #(
        .TOTAL      (V_TOTAL_P),
        .SYNC_START (sync_first(V_VISIBLE_P, V_FP_P)),
        .SYNC_END   (sync_after(V_VISIBLE_P, V_FP_P, V_SYNC_P)),
        .VISIBLE    (V_VISIBLE_P)
    ) u_v (
        .Clk     (Clk),
        .Reset   (Reset),
        .en      (h_wrap),
        .count   (DrawY),
        .wrap    (v_wrap),
        .sync_n  (v_sync_n),
        .visible (v_visible)
    );

    // Phase toggle plus line/frame pulses; pulses are registered so they land on
    // the first cycle at the new position and clear on the following ph=0 edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ph            <= 1'b0;
            frame_count_q <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
        end else begin
            ph            <= ~ph;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            if (v_wrap) begin
                frame_count_q <= frame_count_q + 1'b1;
            end
        end
    end

    // Decoded straight from the current counters so nothing skews against DrawX/DrawY
    assign pixel_clk   = ph;
    assign hs          = h_sync_n;
    assign vs          = v_sync_n;
    assign blank       = h_visible && v_visible;
    assign sync        = 1'b0;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level timing and a
// small-raster instance for frame-level behaviour, both checked every cycle
// against a closed-form model of position versus Clk edges since reset.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        pclk;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        sync;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        fs;
        logic        ls;
        logic [15:0] fc;
    } obs_t;

    typedef struct {
        int         k;
        logic [9:0] x;
        logic [9:0] y;
        logic       pclk;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       ls;
    } vec_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_f, rst_s;
    logic pclk_f, hs_f, vs_f, blank_f, sync_f, fs_f, ls_f;
    logic [9:0] x_f, y_f;
    logic [15:0] fc_f;
    logic pclk_s, hs_s, vs_s, blank_s, sync_s, fs_s, ls_s;
    logic [9:0] x_s, y_s;
    logic [15:0] fc_s;

    int tests_run = 0;
    int tests_failed = 0;
    int k_f = 0;
    int k_s = 0;
    int base_s = 0;
    bit mon_en = 1'b0;

    vga_timing_gen dut_f (
        .Clk(clk), .Reset(rst_f), .pixel_clk(pclk_f), .hs(hs_f), .vs(vs_f),
        .blank(blank_f), .sync(sync_f), .DrawX(x_f), .DrawY(y_f),
        .frame_start(fs_f), .line_start(ls_f), .frame_count(fc_f)
    );

    vga_timing_gen #(
        .H_VISIBLE_P(8), .H_FP_P(2), .H_SYNC_P(3), .H_TOTAL_P(16),
        .V_VISIBLE_P(6), .V_FP_P(1), .V_SYNC_P(2), .V_TOTAL_P(12)
    ) dut_s (
        .Clk(clk), .Reset(rst_s), .pixel_clk(pclk_s), .hs(hs_s), .vs(vs_s),
        .blank(blank_s), .sync(sync_s), .DrawX(x_s), .DrawY(y_s),
        .frame_start(fs_s), .line_start(ls_s), .frame_count(fc_s)
    );

    // Position after k Clk edges since reset: one pixel per two edges.
    function automatic obs_t model(input int k, input int ht, input int hv, input int hs0,
                                   input int hs1, input int vt, input int vv, input int vs0,
                                   input int vs1, input int base);
        obs_t o;
        int n, x, y, f;
        n = k / 2;
        x = n % ht;
        y = (n / ht) % vt;
        f = n / (ht * vt);
        o.pclk  = (k % 2) == 1;
        o.hs    = !(x >= hs0 && x < hs1);
        o.vs    = !(y >= vs0 && y < vs1);
        o.blank = (x < hv) && (y < vv);
        o.sync  = 1'b0;
        o.x     = 10'(x);
        o.y     = 10'(y);
        o.fs    = (k % 2 == 0) && (n > 0) && (n % (ht * vt) == 0);
        o.ls    = (k % 2 == 0) && (n > 0) && (x == 0);
        o.fc    = 16'((base + f) % 65536);
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        obs_t of, os, ef, es;
        of = {pclk_f, hs_f, vs_f, blank_f, sync_f, x_f, y_f, fs_f, ls_f, fc_f};
        os = {pclk_s, hs_s, vs_s, blank_s, sync_s, x_s, y_s, fs_s, ls_s, fc_s};
        ef = model(k_f, 800, 640, 656, 752, 525, 480, 490, 492, 0);
        es = model(k_s, 16, 8, 10, 13, 12, 6, 7, 9, base_s);
        check("full_cycle", 64'(of), 64'(ef));
        check("small_cycle", 64'(os), 64'(es));
        check("inv_blank_sync", 64'(blank_f && !(hs_f && vs_f)), 64'(0));
        check("inv_range", 64'((x_f <= 10'd799) && (y_f <= 10'd524)), 64'(1));
    endtask

    // Advance one Clk edge, update the edge counts, then compare on the falling edge
    task automatic tick();
        @(posedge clk);
        k_f = rst_f ? 0 : k_f + 1;
        k_s = rst_s ? 0 : k_s + 1;
        @(negedge clk);
        if (mon_en) check_all();
    endtask

    vec_t vecs[13];
    int cnt, first_x, blank_x, ls_cnt, fs_cnt, first_y;
    bit found;

    initial begin
        vecs[0]  = '{k: 0,    x: 10'd0,   y: 10'd0, pclk: 0, hs: 1, vs: 1, blank: 1, ls: 0};
        vecs[1]  = '{k: 1,    x: 10'd0,   y: 10'd0, pclk: 1, hs: 1, vs: 1, blank: 1, ls: 0};
        vecs[2]  = '{k: 2,    x: 10'd1,   y: 10'd0, pclk: 0, hs: 1, vs: 1, blank: 1, ls: 0};
        vecs[3]  = '{k: 1279, x: 10'd639, y: 10'd0, pclk: 1, hs: 1, vs: 1, blank: 1, ls: 0};
        vecs[4]  = '{k: 1280, x: 10'd640, y: 10'd0, pclk: 0, hs: 1, vs: 1, blank: 0, ls: 0};
        vecs[5]  = '{k: 1311, x: 10'd655, y: 10'd0, pclk: 1, hs: 1, vs: 1, blank: 0, ls: 0};
        vecs[6]  = '{k: 1312, x: 10'd656, y: 10'd0, pclk: 0, hs: 0, vs: 1, blank: 0, ls: 0};
        vecs[7]  = '{k: 1503, x: 10'd751, y: 10'd0, pclk: 1, hs: 0, vs: 1, blank: 0, ls: 0};
        vecs[8]  = '{k: 1504, x: 10'd752, y: 10'd0, pclk: 0, hs: 1, vs: 1, blank: 0, ls: 0};
        vecs[9]  = '{k: 1599, x: 10'd799, y: 10'd0, pclk: 1, hs: 1, vs: 1, blank: 0, ls: 0};
        vecs[10] = '{k: 1600, x: 10'd0,   y: 10'd1, pclk: 0, hs: 1, vs: 1, blank: 1, ls: 1};
        vecs[11] = '{k: 1601, x: 10'd0,   y: 10'd1, pclk: 1, hs: 1, vs: 1, blank: 1, ls: 0};
        vecs[12] = '{k: 1602, x: 10'd1,   y: 10'd1, pclk: 0, hs: 1, vs: 1, blank: 1, ls: 0};

        // Reset both instances
        rst_f = 1'b1;
        rst_s = 1'b1;
        base_s = 0;
        tick();
        tick();
        mon_en = 1'b1;
        tick();
        check("rst_hs_vs_blank_sync", {60'd0, hs_f, vs_f, blank_f, sync_f}, 64'b1110);
        check("rst_pulses", {62'd0, fs_f, ls_f}, 64'd0);
        check("rst_pos_fc", {28'd0, x_f, y_f, fc_f}, 64'd0);
        rst_f = 1'b0;
        rst_s = 1'b0;

        // Table-driven line vectors on the full-size raster
        for (int i = 0; i < 13; i++) begin
            while (k_f < vecs[i].k) tick();
            check($sformatf("vec%0d_xy", i), {44'd0, x_f, y_f}, {44'd0, vecs[i].x, vecs[i].y});
            check($sformatf("vec%0d_flags", i), {59'd0, pclk_f, hs_f, vs_f, blank_f, ls_f},
                  {59'd0, vecs[i].pclk, vecs[i].hs, vecs[i].vs, vecs[i].blank, vecs[i].ls});
        end

        // One full line: hs width and start, blank fall, single line_start
        rst_f = 1'b1;
        tick();
        rst_f = 1'b0;
        cnt = 0; first_x = -1; blank_x = -1; ls_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            tick();
            if (!hs_f) begin
                cnt++;
                if (first_x < 0) first_x = int'(x_f);
            end
            if (!blank_f && blank_x < 0) blank_x = int'(x_f);
            if (ls_f) ls_cnt++;
        end
        check("line_hs_low_clk", 64'(cnt), 64'd192);
        check("line_hs_first_x", 64'(first_x), 64'd656);
        check("line_blank_fall_x", 64'(blank_x), 64'd640);
        check("line_start_count", 64'(ls_cnt), 64'd1);

        // One full frame on the small raster
        rst_s = 1'b1;
        base_s = 0;
        tick();
        rst_s = 1'b0;
        cnt = 0; first_y = -1; fs_cnt = 0;
        for (int i = 0; i < 384; i++) begin
            tick();
            if (!vs_s) begin
                cnt++;
                if (first_y < 0) first_y = int'(y_s);
            end
            if (fs_s) fs_cnt++;
        end
        check("frame_vs_low_clk", 64'(cnt), 64'd64);
        check("frame_vs_first_y", 64'(first_y), 64'd7);
        check("frame_start_count", 64'(fs_cnt), 64'd1);
        check("frame_count_one", 64'(fc_s), 64'd1);

        // Mid-frame reset at (10,4)
        found = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin
            tick();
            if (x_s == 10'd10 && y_s == 10'd4) found = 1'b1;
        end
        check("midreset_reach", 64'(found), 64'd1);
        rst_s = 1'b1;
        base_s = 0;
        fs_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (fs_s || ls_s) fs_cnt++;
        end
        check("midreset_no_pulse", 64'(fs_cnt), 64'd0);
        check("midreset_outputs", {39'd0, pclk_s, hs_s, vs_s, blank_s, x_s, y_s, fc_s[0]},
              {39'd0, 1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0});
        rst_s = 1'b0;
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick();
            cnt++;
            if (fs_s) found = 1'b1;
        end
        check("midreset_next_frame_clk", 64'(cnt), 64'd384);

        // frame_count wrap from 65535
        for (int i = 0; i < 20; i++) tick();
        force dut_s.frame_count_q = 16'hFFFF;
        base_s = (65535 - ((k_s / 2) / 192)) % 65536;
        tick();
        release dut_s.frame_count_q;
        check("fc_forced", 64'(fc_s), 64'hFFFF);
        found = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin
            tick();
            if (fs_s) found = 1'b1;
        end
        check("fc_wrap_pulse", 64'(found), 64'd1);
        check("fc_wrap_zero", 64'(fc_s), 64'd0);

        // Random run lengths and reset pulses, checked cycle by cycle against the model
        for (int r = 0; r < 20; r++) begin
            int run_len;
            run_len = $urandom_range(1, 700);
            for (int i = 0; i < run_len; i++) tick();
            rst_s = 1'b1;
            base_s = 0;
            if ($urandom_range(0, 3) == 0) rst_f = 1'b1;
            run_len = $urandom_range(1, 3);
            for (int i = 0; i < run_len; i++) tick();
            rst_s = 1'b0;
            rst_f = 1'b0;
        end
        for (int i = 0; i < 400; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
